// File: rtl/machine_csr_file.sv
// Machine-mode CSR file for a single-hart RV32 core: machine status/trap CSRs,
// interrupt registration and prioritisation, trap entry and MRET redirection.
// Optional feature: define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret
// counters; without it those addresses decode as unimplemented.

package machine_csr_pkg;
    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_op_t;
endpackage

module machine_csr_file
    import machine_csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          HART_ID     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  csr_op_t             csr_op_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [XLEN-1:0]     csr_wdata_i,
    input  logic                csr_src_zero_i,
    output logic [XLEN-1:0]     csr_rdata_o,
    output logic                csr_illegal_o,
    input  logic                exc_req_i,
    input  logic [4:0]          exc_cause_i,
    input  logic [XLEN-1:0]     exc_pc_i,
    input  logic [XLEN-1:0]     exc_tval_i,
    input  logic                mret_i,
    input  logic                irq_ok_i,
    input  logic                retire_i,
    input  logic                ext_irq_i,
    input  logic                sw_irq_i,
    input  logic                tmr_irq_i,
    input  logic [NUM_IRQ-1:0]  plat_irq_i,
    output logic                redirect_o,
    output logic [XLEN-1:0]     redirect_pc_o,
    output logic                irq_pending_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

    // RV32I with MXL=1
    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
    // Only MEI/MSI/MTI and the platform lines are real interrupt sources
    localparam logic [31:0] MIE_MASK = 32'h0000_0888
                                     | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mip_q, mip_d;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`else
    logic        unused_retire;
    assign unused_retire = retire_i;
`endif

    logic [31:0] rd_val;
    logic        rd_impl;
    logic        write_req;
    logic        ro_target;
    logic        illegal;
    logic [31:0] wval;
    logic        csr_we;
    logic [31:0] irq_lines;
    logic [31:0] irq_enabled;
    logic [4:0]  irq_cause;
    logic        irq_take;
    logic [31:0] mtvec_base;

    // Raw interrupt sources laid out in their mip bit positions
    assign irq_lines = (32'(plat_irq_i) << 16)
                     | (32'(ext_irq_i)  << 11)
                     | (32'(tmr_irq_i)  << 7)
                     | (32'(sw_irq_i)   << 3);

    // CSR read decode; rd_impl flags addresses that exist in this build
    always_comb begin
        rd_val  = 32'h0;
        rd_impl = 1'b1;
        case (csr_addr_i)
            A_MSTATUS:   rd_val = (32'(mstatus_mie_q) << 3)
                                | (32'(mstatus_mpie_q) << 7)
                                | 32'h0000_1800;
            A_MISA:      rd_val = MISA_VAL;
            A_MIE:       rd_val = mie_q;
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MTVAL:     rd_val = mtval_q;
            A_MIP:       rd_val = mip_q;
            A_MHARTID:   rd_val = 32'(HART_ID);
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    rd_val = mcycle_q[31:0];
            A_MCYCLEH:   rd_val = mcycle_q[63:32];
            A_MINSTRET:  rd_val = minstret_q[31:0];
            A_MINSTRETH: rd_val = minstret_q[63:32];
`endif
            default:     rd_impl = 1'b0;
        endcase
    end

    // Write qualification and read-modify-write value
    always_comb begin
        write_req = (csr_op_i == CSR_RW)
                  | (((csr_op_i == CSR_RS) | (csr_op_i == CSR_RC)) & ~csr_src_zero_i);
        ro_target = (csr_addr_i[11:8] == 4'hF) | (csr_addr_i == A_MISA);
        illegal   = (csr_op_i != CSR_NOP) & (~rd_impl | (write_req & ro_target));
        case (csr_op_i)
            CSR_RW:  wval = csr_wdata_i;
            CSR_RS:  wval = rd_val | csr_wdata_i;
            CSR_RC:  wval = rd_val & ~csr_wdata_i;
            default: wval = rd_val;
        endcase
    end

    // Interrupt selection: MEI > MSI > MTI > lowest-numbered platform line
    always_comb begin
        irq_enabled = mip_q & mie_q;
        irq_cause   = 5'd0;
        if (irq_enabled[11]) begin
            irq_cause = 5'd11;
        end else if (irq_enabled[3]) begin
            irq_cause = 5'd3;
        end else if (irq_enabled[7]) begin
            irq_cause = 5'd7;
        end else begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (irq_enabled[16 + i]) begin
                    irq_cause = 5'(16 + i);
                end
            end
        end
        irq_take = mstatus_mie_q & irq_ok_i & (|irq_enabled) & ~exc_req_i;
    end

    assign csr_we     = write_req & ~illegal & ~exc_req_i & ~irq_take & ~mret_i;
    assign mtvec_base = {mtvec_q[31:2], 2'b00};

    assign csr_rdata_o   = rd_impl ? rd_val : 32'h0;
    assign csr_illegal_o = illegal;
    assign irq_pending_o = ~rst & mstatus_mie_q & (|irq_enabled);

    // Redirect target: exception > interrupt > MRET
    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        if (!rst) begin
            if (exc_req_i) begin
                redirect_o    = 1'b1;
                redirect_pc_o = mtvec_base;
            end else if (irq_take) begin
                redirect_o    = 1'b1;
                redirect_pc_o = mtvec_q[0] ? mtvec_base + (32'(irq_cause) << 2)
                                           : mtvec_base;
            end else if (mret_i) begin
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_q;
            end
        end
    end

    // Next-state for all CSRs; a trap or MRET discards the CSR write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = irq_lines;
`ifdef CSR_COUNTERS_EN
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + 64'(retire_i);
`endif
        if (exc_req_i) begin
            mepc_d         = exc_pc_i & ~32'h3;
            mcause_d       = {27'h0, exc_cause_i};
            mtval_d        = exc_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (irq_take) begin
            mepc_d         = exc_pc_i & ~32'h3;
            mcause_d       = {1'b1, 26'h0, irq_cause};
            mtval_d        = 32'h0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                A_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                A_MIE:       mie_d      = wval & MIE_MASK;
                A_MTVEC:     mtvec_d    = wval & ~32'h2;
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      mepc_d     = wval & ~32'h3;
                A_MCAUSE:    mcause_d   = wval;
                A_MTVAL:     mtval_d    = wval;
`ifdef CSR_COUNTERS_EN
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
                A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
                A_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
`endif
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset overriding everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= MTVEC_RESET & ~32'h2;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mip_q          <= 32'h0;
`ifdef CSR_COUNTERS_EN
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
`endif
        end
    end

endmodule

// File: tb/tb_machine_csr_file.sv
// Scoreboard bench for machine_csr_file: stimulus computes expected outputs
// from a behavioural CSR model and queues them; a negedge monitor compares.
module tb_machine_csr_file;
    import machine_csr_pkg::*;

    localparam int          NIRQ = 4;
    localparam logic [31:0] MTR  = 32'h0000_1000;
    localparam int          HID  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    csr_op_t          csr_op_i = CSR_NOP;
    logic [11:0]      csr_addr_i = '0;
    logic [31:0]      csr_wdata_i = '0;
    logic             csr_src_zero_i = 1'b0;
    logic [31:0]      csr_rdata_o;
    logic             csr_illegal_o;
    logic             exc_req_i = 1'b0;
    logic [4:0]       exc_cause_i = '0;
    logic [31:0]      exc_pc_i = '0;
    logic [31:0]      exc_tval_i = '0;
    logic             mret_i = 1'b0;
    logic             irq_ok_i = 1'b0;
    logic             retire_i = 1'b0;
    logic             ext_irq_i = 1'b0;
    logic             sw_irq_i = 1'b0;
    logic             tmr_irq_i = 1'b0;
    logic [NIRQ-1:0]  plat_irq_i = '0;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic             irq_pending_o;

    machine_csr_file #(
        .XLEN(32), .NUM_IRQ(NIRQ), .MTVEC_RESET(MTR), .HART_ID(HID)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_src_zero_i(csr_src_zero_i), .csr_rdata_o(csr_rdata_o),
        .csr_illegal_o(csr_illegal_o), .exc_req_i(exc_req_i),
        .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .irq_ok_i(irq_ok_i), .retire_i(retire_i),
        .ext_irq_i(ext_irq_i), .sw_irq_i(sw_irq_i), .tmr_irq_i(tmr_irq_i),
        .plat_irq_i(plat_irq_i), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .irq_pending_o(irq_pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              rst;
        bit [1:0]        op;
        bit [11:0]       addr;
        bit [31:0]       wdata;
        bit              sz;
        bit              exc;
        bit [4:0]        cause;
        bit [31:0]       pc;
        bit [31:0]       tval;
        bit              mret;
        bit              irq_ok;
        bit              retire;
        bit              ext, sw, tmr;
        bit [NIRQ-1:0]   plat;
    } stim_t;

    typedef struct {
        bit         chk;
        bit [11:0]  addr;
        bit [31:0]  rdata;
        bit         ill;
        bit         red;
        bit [31:0]  rpc;
        bit         pend;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;
    bit   chk_en = 1'b0;

    // Behavioural model state, in architectural terms
    bit          m_mie, m_mpie;
    bit [31:0]   m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_ip;
    bit [63:0]   m_cyc, m_ret;

    function automatic bit [31:0] model_read(input bit [11:0] a, output bit impl);
        impl = 1'b1;
        case (a)
            12'h300: return (32'(m_mie) << 3) + (32'(m_mpie) << 7) + 32'h1800;
            12'h301: return 32'h4000_0100;
            12'h304: return m_ie;
            12'h305: return m_tvec;
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hF14: return 32'(HID);
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
`endif
            default: begin
                impl = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    // Highest-priority enabled interrupt cause
    function automatic int pick(input bit [31:0] en);
        if (en[11]) return 11;
        if (en[3]) return 3;
        if (en[7]) return 7;
        for (int i = 0; i < NIRQ; i++)
            if (en[16 + i]) return 16 + i;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t      e;
        bit        impl, wr, ill, take;
        bit [31:0] r, nv, en, base, lines, ie_mask;
        bit [63:0] cyc_n, ret_n;
        int        c;
        @(posedge clk);
        #1;
        rst = s.rst; csr_op_i = csr_op_t'(s.op); csr_addr_i = s.addr;
        csr_wdata_i = s.wdata; csr_src_zero_i = s.sz; exc_req_i = s.exc;
        exc_cause_i = s.cause; exc_pc_i = s.pc; exc_tval_i = s.tval;
        mret_i = s.mret; irq_ok_i = s.irq_ok; retire_i = s.retire;
        ext_irq_i = s.ext; sw_irq_i = s.sw; tmr_irq_i = s.tmr; plat_irq_i = s.plat;

        r    = model_read(s.addr, impl);
        wr   = (s.op == 2'd1) || (s.op != 2'd0 && !s.sz);
        ill  = (s.op != 2'd0) && (!impl || (wr && (s.addr[11:8] == 4'hF || s.addr == 12'h301)));
        en   = m_ip & m_ie;
        take = m_mie && s.irq_ok && (en != 0) && !s.exc;
        c    = pick(en);
        base = m_tvec & ~32'h3;

        e.chk = chk_en; e.addr = s.addr; e.rdata = r; e.ill = ill;
        e.pend = !s.rst && m_mie && (en != 0);
        e.red = 1'b0; e.rpc = 32'h0;
        if (!s.rst) begin
            if (s.exc) begin
                e.red = 1'b1; e.rpc = base;
            end else if (take) begin
                e.red = 1'b1; e.rpc = m_tvec[0] ? base + 32'(4 * c) : base;
            end else if (s.mret) begin
                e.red = 1'b1; e.rpc = m_epc;
            end
        end
        sb.push_back(e);

        lines = 32'(s.plat) * 32'h1_0000 + (32'(s.ext) << 11) + (32'(s.tmr) << 7) + (32'(s.sw) << 3);
        ie_mask = 32'h888 + ((32'd1 << NIRQ) - 1) * 32'h1_0000;
        if (s.rst) begin
            m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = MTR & ~32'h2;
            m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_ip = 0;
            m_cyc = 0; m_ret = 0;
        end else begin
            cyc_n = m_cyc + 1;
            ret_n = m_ret + 64'(s.retire);
            if (s.exc) begin
                m_epc = s.pc & ~32'h3; m_cause = 32'(s.cause); m_tval = s.tval;
                m_mpie = m_mie; m_mie = 0;
            end else if (take) begin
                m_epc = s.pc & ~32'h3; m_cause = 32'h8000_0000 + 32'(c); m_tval = 0;
                m_mpie = m_mie; m_mie = 0;
            end else if (s.mret) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (wr && !ill) begin
                case (s.op)
                    2'd1:    nv = s.wdata;
                    2'd2:    nv = r | s.wdata;
                    default: nv = r & ~s.wdata;
                endcase
                case (s.addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_ie = nv & ie_mask;
                    12'h305: m_tvec = nv & ~32'h2;
                    12'h340: m_scratch = nv;
                    12'h341: m_epc = nv & ~32'h3;
                    12'h342: m_cause = nv;
                    12'h343: m_tval = nv;
                    12'hB00: cyc_n = {m_cyc[63:32], nv};
                    12'hB80: cyc_n = {nv, m_cyc[31:0]};
                    12'hB02: ret_n = {m_ret[63:32], nv};
                    12'hB82: ret_n = {nv, m_ret[31:0]};
                    default: ;
                endcase
            end
            m_cyc = cyc_n;
            m_ret = ret_n;
            m_ip  = lines;
        end
    endtask

    task automatic cmp(input string n, input bit [11:0] a, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s addr=%03h actual=%08h required=%08h", n, a, act, req);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                txn++;
                cmp("rdata", e.addr, csr_rdata_o, e.rdata);
                cmp("illegal", e.addr, 32'(csr_illegal_o), 32'(e.ill));
                cmp("redirect", e.addr, 32'(redirect_o), 32'(e.red));
                cmp("redirect_pc", e.addr, redirect_pc_o, e.rpc);
                cmp("irq_pending", e.addr, 32'(irq_pending_o), 32'(e.pend));
                $display("txn %0d addr=%03h rdata=%08h ill=%0b red=%0b pc=%08h pend=%0b",
                         txn, e.addr, csr_rdata_o, csr_illegal_o, redirect_o,
                         redirect_pc_o, irq_pending_o);
            end
        end
    end

    task automatic csr(input bit [1:0] op, input bit [11:0] a, input bit [31:0] d, input bit sz);
        stim_t s;
        s = idle();
        s.op = op; s.addr = a; s.wdata = d; s.sz = sz;
        step(s);
    endtask

    initial begin
        stim_t s;
        bit [11:0] alist [18];
        alist = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h343, 12'h344, 12'hF14, 12'hF11, 12'h7C0, 12'hB00, 12'hB80,
                  12'hB02, 12'hB82, 12'h000, 12'h3A0};

        // Reset: first cycle unchecked (state still unknown), second checked
        s = idle(); s.rst = 1;
        step(s);
        chk_en = 1'b1;
        s.exc = 1; s.op = 2'd1; s.addr = 12'h305;
        step(s);
        csr(2'd2, 12'h305, 32'h0, 1'b1);              // mtvec reset value

        // mtvec legalisation
        csr(2'd1, 12'h305, 32'h8000_0103, 1'b0);
        csr(2'd2, 12'h305, 32'h0, 1'b1);

        // Vectored external interrupt
        csr(2'd1, 12'h300, 32'h8, 1'b0);
        csr(2'd1, 12'h304, 32'hFFFF_FFFF, 1'b0);
        csr(2'd2, 12'h304, 32'h0, 1'b1);
        csr(2'd1, 12'h304, 32'h800, 1'b0);
        csr(2'd1, 12'h305, 32'h101, 1'b0);
        s = idle(); s.ext = 1; s.irq_ok = 1; step(s);  // cycle N
        s.pc = 32'h2000_0046; step(s);                   // N+1: trap
        csr(2'd2, 12'h342, 32'h0, 1'b1);
        csr(2'd2, 12'h300, 32'h0, 1'b1);
        csr(2'd2, 12'h341, 32'h0, 1'b1);
        csr(2'd2, 12'h344, 32'h0, 1'b1);

        // MRET back
        s = idle(); s.mret = 1; step(s);
        csr(2'd2, 12'h300, 32'h0, 1'b1);

        // Exception beats MRET and CSR write
        csr(2'd1, 12'h340, 32'h0000_AAAA, 1'b0);
        s = idle(); s.exc = 1; s.cause = 5'd2; s.mret = 1; s.op = 2'd1;
        s.addr = 12'h340; s.wdata = 32'h5555; s.pc = 32'h300; s.tval = 32'h77;
        step(s);
        csr(2'd2, 12'h342, 32'h0, 1'b1);
        csr(2'd2, 12'h340, 32'h0, 1'b1);
        csr(2'd2, 12'h343, 32'h0, 1'b1);

        // Write suppression and read-only/unimplemented decode
        csr(2'd2, 12'h340, 32'hFFFF, 1'b1);
        csr(2'd3, 12'h340, 32'hFFFF, 1'b1);
        csr(2'd2, 12'h340, 32'h0, 1'b1);
        csr(2'd1, 12'hF14, 32'h1234, 1'b0);
        csr(2'd2, 12'hF14, 32'h0, 1'b1);
        csr(2'd1, 12'h301, 32'h0, 1'b0);
        csr(2'd2, 12'h301, 32'h0, 1'b1);
        csr(2'd2, 12'h7C0, 32'h0, 1'b1);
        csr(2'd0, 12'h7C0, 32'h0, 1'b0);
        csr(2'd1, 12'h344, 32'hFFFF_FFFF, 1'b0);

        // Counter low-half carry (or absence of counters)
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        csr(2'd2, 12'hB00, 32'h0, 1'b1);
        csr(2'd2, 12'hB80, 32'h0, 1'b1);
        csr(2'd2, 12'hB02, 32'h0, 1'b1);

        // Reset overrides same-cycle trap and write
        s = idle(); s.rst = 1; s.exc = 1; s.cause = 5'd5; s.op = 2'd1; s.addr = 12'h340;
        s.wdata = 32'hDEAD; s.ext = 1;
        step(s);
        csr(2'd2, 12'h340, 32'h0, 1'b1);
        csr(2'd2, 12'h344, 32'h0, 1'b1);
        csr(2'd2, 12'h342, 32'h0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst    = ($urandom_range(0, 149) == 0);
            s.op     = 2'($urandom_range(0, 3));
            s.addr   = alist[$urandom_range(0, 17)];
            s.wdata  = ($urandom_range(0, 3) == 0) ? 32'(1 << $urandom_range(0, 31)) : $urandom;
            s.sz     = ($urandom_range(0, 3) == 0);
            s.exc    = ($urandom_range(0, 15) == 0);
            s.cause  = 5'($urandom_range(0, 15));
            s.pc     = $urandom;
            s.tval   = $urandom;
            s.mret   = ($urandom_range(0, 15) == 0);
            s.irq_ok = ($urandom_range(0, 1) == 1);
            s.retire = ($urandom_range(0, 1) == 1);
            s.ext    = ($urandom_range(0, 7) == 0);
            s.sw     = ($urandom_range(0, 7) == 0);
            s.tmr    = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < NIRQ; k++) s.plat[k] = ($urandom_range(0, 7) == 0);
            step(s);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/machine_csr_file.md
MACHINE_CSR_FILE -- requirements
Module: machine_csr_file

Interface
REQ-001 SHALL have parameter XLEN, 32, data width (only 32 supported).
REQ-002 SHALL have parameter NUM_IRQ, 4, platform interrupt lines (1..16), mapped to mip/mie bits 16+i.
REQ-003 SHALL have parameter MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
REQ-004 SHALL have parameter HART_ID, 0, value returned by mhartid.
REQ-005 SHALL have ports, one per line:
 clk  in  1  sole clock; one clock, all state on rising edge
 rst  in  1  synchronous, active-high reset
 csr_op_i  in  csr_op_t  NOP/RW/RS/RC
 csr_addr_i  in  12  CSR number
 csr_wdata_i  in  XLEN  rs1 value or zero-extended uimm
 csr_src_zero_i  in  1  rs1 field/uimm is zero
 csr_rdata_o  out  XLEN  combinational read data
 csr_illegal_o  out  1  access to unimplemented CSR or write to read-only CSR
 exc_req_i  in  1  synchronous exception this cycle
 exc_cause_i  in  5  exception code
 exc_pc_i  in  XLEN  PC of trapping/interrupted instruction
 exc_tval_i  in  XLEN  trap value
 mret_i  in  1  MRET executing
 irq_ok_i  in  1  core at interruptible instruction boundary
 retire_i  in  1  one instruction retired
 ext_irq_i / sw_irq_i / tmr_irq_i  in  1 each  MEI/MSI/MTI sources
 plat_irq_i  in  NUM_IRQ  platform sources
 redirect_o  out  1  trap entry or MRET this cycle
 redirect_pc_o  out  XLEN  target PC when redirect_o
 irq_pending_o  out  1  enabled interrupt pending and mstatus.MIE=1

Function
REQ-006 SHALL implement mstatus 0x300 (MIE, MPIE; MPP reads 2'b11; others 0), misa 0x301 (RO, RV32I), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (write ignored), mhartid 0xF14 (RO).
REQ-007 SHALL suppress CSR write when op=NOP, or op=RS/RC with csr_src_zero_i=1; RW always writes.
REQ-008 SHALL compute RS as rdata|wdata and RC as rdata&~wdata; new value visible on the next cycle.
REQ-009 SHALL assert csr_illegal_o for unimplemented addresses, or a write (per REQ-007) to 0xFxx/misa; no state changes on illegal access.
REQ-010 SHALL force mepc[1:0]=0, mtvec[1]=0, mie bits outside {3,7,11,16..16+NUM_IRQ-1} to 0.
REQ-011 SHALL register all interrupt inputs once into mip; an input asserted in cycle N is visible in mip at N+1, earliest trap entry at N+1.
REQ-012 SHALL take an interrupt when mstatus.MIE & irq_ok_i & |(mip&mie) & ~exc_req_i; priority MEI > MSI > MTI > plat_irq lowest index.
REQ-013 SHALL on trap entry, in one cycle: mepc<=exc_pc_i, mcause<={intr,cause}, mtval<=exc_tval_i (0 for interrupts), MPIE<=MIE, MIE<=0, redirect_o=1.
REQ-014 SHALL drive redirect_pc_o = mtvec base for exceptions or mtvec.MODE=0; base+4*cause for interrupts with MODE=1.
REQ-015 SHALL on mret_i: MIE<=MPIE, MPIE<=1, redirect_o=1, redirect_pc_o=mepc.
REQ-016 SHALL prioritise exception > interrupt > MRET > CSR write in the same cycle; lower-priority state updates discarded.
REQ-017 SHALL drive redirect_o=0 and redirect_pc_o=0 when no trap/MRET.

Reset
REQ-018 SHALL on rst: all CSRs 0 except mtvec=MTVEC_RESET; registered mip cleared; outputs redirect_o=0, irq_pending_o=0, csr_illegal_o per combinational decode.
REQ-019 SHALL let rst override any same-cycle trap, MRET, or CSR write.

Configuration
REQ-020 SHALL, with CSR_COUNTERS_EN defined, implement 64-bit mcycle (0xB00/0xB80, +1 every cycle) and minstret (0xB02/0xB82, +1 on retire_i), carry low->high half; CSR write to a half overrides that cycle's increment of that counter.
REQ-021 SHALL, without CSR_COUNTERS_EN, treat 0xB00/0xB80/0xB02/0xB82 as unimplemented (csr_illegal_o=1), with no counter flops.

Verification
REQ-022 Reset, then CSRRW 0x305 wdata=32'h8000_0103 -> read 0x305 = 32'h8000_0101.
REQ-023 mstatus.MIE=1, mie=0x800, ext_irq_i=1 at cycle N, irq_ok_i=1, mtvec=32'h100 MODE=1 -> redirect_o at N+1, redirect_pc_o=32'h12C, mcause=32'h8000_000B, MIE=0, MPIE=1.
REQ-024 exc_req_i cause=2, mret_i, and CSRRW mscratch same cycle -> mcause=2, mscratch unchanged, redirect_pc_o=mtvec base.
REQ-025 After trap, mret_i -> redirect_pc_o=mepc, MIE=1, MPIE=1.
REQ-026 CSRRS 0x340 with csr_src_zero_i=1 -> no write; read 0xF14 write-form -> csr_illegal_o=1, state unchanged.
REQ-027 CSR_COUNTERS_EN: write mcycle low 32'hFFFF_FFFF -> next cycle 0, mcycleh +1; without macro, read 0xB00 -> csr_illegal_o=1.
